// File: rtl/prog_buffer_pkg.sv
// Shared types and constants for the PGM8755 programming staging buffer.
package prog_buffer_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    DRAIN = 2'd1,
    PROG  = 2'd2
  } state_t;

  localparam logic [7:0] ERASED_DEFAULT = 8'hFF;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/prog_buffer_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
module buffer_ram
  import prog_buffer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem_r [0:DEPTH-1];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port; output holds between reads
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/prog_buffer.sv
// Staging buffer between host byte link and EPROM programming sequencer.
// Optional running checksum output enabled by PROG_BUFFER_CHECKSUM_EN.
module prog_buffer
  import prog_buffer_pkg::*;
#(
  parameter int              DATA_W = 8,
  parameter int              ADDR_W = 11,
  parameter logic [DATA_W-1:0] ERASED = ERASED_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              prog_req,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              prog_mode,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
`ifdef PROG_BUFFER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(depth_of(ADDR_W));
  localparam logic [ADDR_W-1:0] PTR_MAX   = {ADDR_W{1'b1}};

  state_t            state_r;
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic              wr_fire_s;
  logic              rd_fire_s;
  logic              rd_valid_r;
  logic              erase_r;
  logic [DATA_W-1:0] ram_q_s;
  logic [DATA_W-1:0] rd_hold_r;
  logic [DATA_W-1:0] rd_data_s;

  assign full      = (count_r == DEPTH_CNT);
  assign empty     = (count_r == {(ADDR_W+1){1'b0}});
  assign wr_ready  = (state_r == LOAD) && !full && !clear;
  assign wr_fire_s = wr_en && wr_ready;
  assign rd_fire_s = rd_en && (state_r == PROG);
  assign count     = count_r;
  assign rd_valid  = rd_valid_r;
  assign rd_data   = rd_data_s;

  buffer_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (wr_fire_s),
    .waddr(wr_ptr_r),
    .wdata(wr_data),
    .re   (rd_fire_s),
    .raddr(rd_addr),
    .rdata(ram_q_s)
  );

  // Mode FSM; DRAIN gives the final write one cycle to land before reads open
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_r   <= LOAD;
      prog_mode <= 1'b0;
    end else begin
      case (state_r)
        LOAD: begin
          state_r   <= prog_req ? DRAIN : LOAD;
          prog_mode <= 1'b0;
        end
        DRAIN: begin
          state_r   <= PROG;
          prog_mode <= 1'b1;
        end
        PROG: begin
          state_r   <= prog_req ? PROG : LOAD;
          prog_mode <= prog_req;
        end
        default: begin
          state_r   <= LOAD;
          prog_mode <= 1'b0;
        end
      endcase
    end
  end

  // Fill count and write pointer; pointer saturates once the buffer is full
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_r  <= {(ADDR_W+1){1'b0}};
      wr_ptr_r <= {ADDR_W{1'b0}};
    end else if (wr_fire_s) begin
      count_r  <= count_r + (ADDR_W+1)'(1'b1);
      wr_ptr_r <= (wr_ptr_r == PTR_MAX) ? wr_ptr_r : wr_ptr_r + ADDR_W'(1'b1);
    end else begin
      count_r  <= count_r;
      wr_ptr_r <= wr_ptr_r;
    end
  end

  // Read pipeline: the erase decision is taken with the address, data follows from RAM
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_r <= 1'b0;
      erase_r    <= 1'b0;
      rd_hold_r  <= {DATA_W{1'b0}};
    end else begin
      rd_valid_r <= rd_fire_s;
      erase_r    <= rd_fire_s ? ({1'b0, rd_addr} >= count_r) : erase_r;
      rd_hold_r  <= rd_data_s;
    end
  end

  // Output mux: fresh read data on the valid cycle, otherwise the held value
  always_comb begin
    rd_data_s = rd_hold_r;
    if (rd_valid_r) begin
      rd_data_s = erase_r ? ERASED : ram_q_s;
    end else begin
      rd_data_s = rd_hold_r;
    end
  end

`ifdef PROG_BUFFER_CHECKSUM_EN
  // Running modulo sum of accepted writes
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      checksum <= {DATA_W{1'b0}};
    end else if (wr_fire_s) begin
      checksum <= checksum + wr_data;
    end else begin
      checksum <= checksum;
    end
  end
`endif

endmodule

// File: tb/tb_prog_buffer.sv
// Self-checking bench for prog_buffer: vector table, directed fill/checksum runs, random vs. model.
module tb_prog_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        prog_req;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        rd_en;
  logic [10:0] rd_addr;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        prog_mode;
  logic [11:0] count;
  logic        full;
  logic        empty;
`ifdef PROG_BUFFER_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  always #5 clk = ~clk;

  prog_buffer dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .prog_req (prog_req),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .prog_mode(prog_mode),
    .count    (count),
    .full     (full),
    .empty    (empty)
`ifdef PROG_BUFFER_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Reference model: buffer contents, fill level, mode (0 load, 1 drain, 2 prog)
  logic [7:0] mem_m [0:2047];
  int         cnt_m;
  int         mode_m;
  logic       rv_m;
  logic [7:0] rd_m;
  logic [7:0] sum_m;

  typedef struct {
    logic        we;
    logic [7:0]  wd;
    logic        pr;
    logic        re;
    logic [10:0] ra;
    logic        cl;
    int          cnt;
    logic        pm;
    logic        rv;
    logic [7:0]  rd;
  } vec_t;

  vec_t tbl [28];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; clear = 1'b0; prog_req = 1'b0; wr_en = 1'b0;
    wr_data = 8'h00; rd_en = 1'b0; rd_addr = 11'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    cnt_m = 0; mode_m = 0; rv_m = 1'b0; rd_m = 8'h00; sum_m = 8'h00;
  endtask

  // One clock: drive inputs, check wr_ready, advance model, sample after the edge
  task automatic tick(input logic we, input logic [7:0] wd, input logic pr,
                      input logic re, input logic [10:0] ra, input logic cl);
    logic ready;
    wr_en = we; wr_data = wd; prog_req = pr; rd_en = re; rd_addr = ra; clear = cl;
    #1;
    ready = (mode_m == 0) && (cnt_m < 2048) && !cl;
    chk("wr_ready", {31'd0, wr_ready}, {31'd0, ready});
    rv_m = (mode_m == 2) && re;
    if (rv_m) rd_m = (int'(ra) < cnt_m) ? mem_m[ra] : 8'hFF;
    if (ready && we) begin
      mem_m[cnt_m] = wd;
      cnt_m++;
      sum_m = sum_m + wd;
    end
    if (cl) begin
      cnt_m = 0; sum_m = 8'h00; mode_m = 0;
    end else if (mode_m == 0) mode_m = pr ? 1 : 0;
    else if (mode_m == 1) mode_m = 2;
    else mode_m = pr ? 2 : 0;
    @(posedge clk); #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".count"},     {20'd0, count},     32'(cnt_m));
    chk({tag, ".empty"},     {31'd0, empty},     {31'd0, cnt_m == 0});
    chk({tag, ".full"},      {31'd0, full},      {31'd0, cnt_m == 2048});
    chk({tag, ".prog_mode"}, {31'd0, prog_mode}, {31'd0, mode_m == 2});
    chk({tag, ".rd_valid"},  {31'd0, rd_valid},  {31'd0, rv_m});
    chk({tag, ".rd_data"},   {24'd0, rd_data},   {24'd0, rd_m});
`ifdef PROG_BUFFER_CHECKSUM_EN
    chk({tag, ".checksum"},  {24'd0, checksum},  {24'd0, sum_m});
`endif
  endtask

  initial begin
    logic        pr_lvl;
    logic [10:0] ra;

    //          we    wd     pr    re    ra       cl    cnt pm    rv    rd
    tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 11'd0,    1'b0, 1, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 11'd0,    1'b0, 2, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 8'h00, 1'b0, 1'b0, 11'd0,    1'b0, 3, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 11'd0,    1'b0, 3, 1'b0, 1'b0, 8'h00};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 11'd0,    1'b0, 3, 1'b1, 1'b0, 8'h00};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 11'd0,    1'b0, 3, 1'b1, 1'b1, 8'hA5};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 11'd1,    1'b0, 3, 1'b1, 1'b1, 8'h3C};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 11'd2,    1'b0, 3, 1'b1, 1'b1, 8'h00};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 11'd0,    1'b0, 3, 1'b1, 1'b0, 8'h00};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 11'd3,    1'b0, 3, 1'b1, 1'b1, 8'hFF};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 11'd2047, 1'b0, 3, 1'b1, 1'b1, 8'hFF};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 11'd1,    1'b0, 3, 1'b1, 1'b1, 8'h3C};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 11'd0,    1'b0, 3, 1'b0, 1'b1, 8'hA5};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 11'd0,    1'b0, 3, 1'b0, 1'b0, 8'hA5};
    tbl[14] = '{1'b1, 8'h11, 1'b0, 1'b0, 11'd0,    1'b0, 4, 1'b0, 1'b0, 8'hA5};
    tbl[15] = '{1'b1, 8'h22, 1'b0, 1'b0, 11'd0,    1'b0, 5, 1'b0, 1'b0, 8'hA5};
    tbl[16] = '{1'b1, 8'h99, 1'b0, 1'b0, 11'd0,    1'b1, 0, 1'b0, 1'b0, 8'hA5};
    tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 11'd0,    1'b0, 0, 1'b0, 1'b0, 8'hA5};
    tbl[18] = '{1'b0, 8'h00, 1'b1, 1'b1, 11'd0,    1'b0, 0, 1'b1, 1'b0, 8'hA5};
    tbl[19] = '{1'b0, 8'h00, 1'b1, 1'b1, 11'd0,    1'b0, 0, 1'b1, 1'b1, 8'hFF};
    tbl[20] = '{1'b0, 8'h00, 1'b0, 1'b0, 11'd0,    1'b0, 0, 1'b0, 1'b0, 8'hFF};
    tbl[21] = '{1'b1, 8'h5A, 1'b1, 1'b0, 11'd0,    1'b0, 1, 1'b0, 1'b0, 8'hFF};
    tbl[22] = '{1'b0, 8'h00, 1'b1, 1'b1, 11'd0,    1'b0, 1, 1'b1, 1'b0, 8'hFF};
    tbl[23] = '{1'b0, 8'h00, 1'b1, 1'b1, 11'd0,    1'b0, 1, 1'b1, 1'b1, 8'h5A};
    tbl[24] = '{1'b0, 8'h00, 1'b1, 1'b0, 11'd0,    1'b1, 0, 1'b0, 1'b0, 8'h5A};
    tbl[25] = '{1'b0, 8'h00, 1'b1, 1'b0, 11'd0,    1'b0, 0, 1'b0, 1'b0, 8'h5A};
    tbl[26] = '{1'b0, 8'h00, 1'b0, 1'b0, 11'd0,    1'b0, 0, 1'b1, 1'b0, 8'h5A};
    tbl[27] = '{1'b0, 8'h00, 1'b0, 1'b0, 11'd0,    1'b0, 0, 1'b0, 1'b0, 8'h5A};

    do_reset();
    chk("reset.count",     {20'd0, count},     32'd0);
    chk("reset.empty",     {31'd0, empty},     32'd1);
    chk("reset.full",      {31'd0, full},      32'd0);
    chk("reset.wr_ready",  {31'd0, wr_ready},  32'd1);
    chk("reset.prog_mode", {31'd0, prog_mode}, 32'd0);
    chk("reset.rd_valid",  {31'd0, rd_valid},  32'd0);
    chk("reset.rd_data",   {24'd0, rd_data},   32'd0);

    for (int i = 0; i < 28; i++) begin
      tick(tbl[i].we, tbl[i].wd, tbl[i].pr, tbl[i].re, tbl[i].ra, tbl[i].cl);
      chk($sformatf("tbl[%0d].count", i),     {20'd0, count},     32'(tbl[i].cnt));
      chk($sformatf("tbl[%0d].empty", i),     {31'd0, empty},     {31'd0, tbl[i].cnt == 0});
      chk($sformatf("tbl[%0d].prog_mode", i), {31'd0, prog_mode}, {31'd0, tbl[i].pm});
      chk($sformatf("tbl[%0d].rd_valid", i),  {31'd0, rd_valid},  {31'd0, tbl[i].rv});
      chk($sformatf("tbl[%0d].rd_data", i),   {24'd0, rd_data},   {24'd0, tbl[i].rd});
    end

`ifdef PROG_BUFFER_CHECKSUM_EN
    do_reset();
    tick(1'b1, 8'hFF, 1'b0, 1'b0, 11'd0, 1'b0);
    tick(1'b1, 8'h02, 1'b0, 1'b0, 11'd0, 1'b0);
    chk("csum.after_writes", {24'd0, checksum}, 32'h01);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 11'd0, 1'b1);
    chk("csum.after_clear", {24'd0, checksum}, 32'h00);
`endif

    // Fill to capacity, then an overflow write that must be dropped
    do_reset();
    tick(1'b1, 8'h5C, 1'b0, 1'b0, 11'd0, 1'b0);
    for (int i = 1; i < 2048; i++) tick(1'b1, 8'($urandom), 1'b0, 1'b0, 11'd0, 1'b0);
    check_model("fill");
    chk("fill.full", {31'd0, full}, 32'd1);
    tick(1'b1, 8'h77, 1'b0, 1'b0, 11'd0, 1'b0);
    chk("overflow.count", {20'd0, count}, 32'd2048);
    tick(1'b0, 8'h00, 1'b1, 1'b0, 11'd0, 1'b0);
    tick(1'b0, 8'h00, 1'b1, 1'b0, 11'd0, 1'b0);
    tick(1'b0, 8'h00, 1'b1, 1'b1, 11'd0, 1'b0);
    chk("overflow.rd0", {24'd0, rd_data}, 32'h5C);
    chk("overflow.rd0_valid", {31'd0, rd_valid}, 32'd1);
    tick(1'b0, 8'h00, 1'b1, 1'b1, 11'd2047, 1'b0);
    check_model("fill.last");
    for (int i = 0; i < 200; i++) begin
      tick(1'b0, 8'h00, 1'b1, 1'($urandom_range(0, 1)), 11'($urandom_range(0, 2047)), 1'b0);
      check_model("fill.rd");
    end

    // Random traffic against the model
    do_reset();
    pr_lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) pr_lvl = ~pr_lvl;
      ra = ($urandom_range(0, 7) == 0) ? 11'd2047 : 11'($urandom_range(0, 40));
      tick(1'($urandom_range(0, 1)), 8'($urandom), pr_lvl, 1'($urandom_range(0, 1)), ra,
           $urandom_range(0, 63) == 0);
      check_model("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
